// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial test-pattern transmitter and the detector benches.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned                DEFAULT_PAT_W   = 4;
  localparam logic [DEFAULT_PAT_W-1:0]   DEFAULT_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Control/status bundle between a pattern-generator user and seq_pattern_gen.
interface seq_pattern_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             x_out;
  logic             bit_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  modport master (
    output start, abort, repeat_cnt, gap_len,
    input  x_out, bit_valid, frame_start, busy, done, sent_cnt
  );

  modport slave (
    input  start, abort, repeat_cnt, gap_len,
    output x_out, bit_valid, frame_start, busy, done, sent_cnt
  );
endinterface

// File: rtl/seq_pattern_gen_piso.sv
// Parallel-load, MSB-first shift register; load has priority over shift.
module piso_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i)       sh_d = data_i;
    else if (shift_i) sh_d = {sh_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sh_q <= '0;
    else       sh_q <= sh_d;
  end

  assign msb_o = sh_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: sends PATTERN MSB-first, repeated, with idle gaps.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W    = DEFAULT_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(DEFAULT_PATTERN),
  parameter int unsigned      CNT_W    = 8,
  parameter int unsigned      GAP_W    = 4,
  parameter logic             IDLE_BIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seq_pattern_gen_if.slave   bus
);

  localparam int unsigned      BIT_W    = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);
  // The shifter runs one bit ahead of x_out, so it is loaded with the MSB already consumed.
  localparam logic [PAT_W-1:0] LOAD_VAL = PATTERN << 1;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic             x_out_q, x_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_pat;
  logic             shift;
  logic             sh_msb;

  piso_shift #(.W(PAT_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .load_i  (start_pat),
    .shift_i (shift),
    .data_i  (LOAD_VAL),
    .msb_o   (sh_msb)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    sent_cnt_d = sent_cnt_q;
    start_pat  = 1'b0;
    shift      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          rep_d      = bus.repeat_cnt;
          gap_len_d  = bus.gap_len;
          sent_cnt_d = '0;
          if (bus.repeat_cnt != '0) begin
            state_d   = ST_SEND;
            start_pat = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bit_q == LAST_BIT) begin
          sent_cnt_d = (sent_cnt_q == '1) ? sent_cnt_q : sent_cnt_q + CNT_W'(1);
          if (rep_q <= CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_len_q == '0) begin
              start_pat = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_len_q;
            end
          end
        end else begin
          shift = 1'b1;
          bit_d = bit_q + BIT_W'(1);
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          state_d   = ST_SEND;
          start_pat = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_pat) bit_d = '0;

    // Outputs are registered copies of what the next state will present.
    x_out_d       = start_pat ? PATTERN[PAT_W-1] : (shift ? sh_msb : IDLE_BIT);
    bit_valid_d   = (state_d == ST_SEND);
    frame_start_d = start_pat;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_q         <= '0;
      rep_q         <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      sent_cnt_q    <= '0;
      x_out_q       <= IDLE_BIT;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      rep_q         <= rep_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      sent_cnt_q    <= sent_cnt_d;
      x_out_q       <= x_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.x_out       = x_out_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: every busy cycle is matched against a queued expectation.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_pattern_gen_if #(.CNT_W(8), .GAP_W(4)) bus ();

  seq_pattern_gen #(
    .PAT_W    (4),
    .PATTERN  (4'b0110),
    .CNT_W    (8),
    .GAP_W    (4),
    .IDLE_BIT (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic x;
    logic bv;
    logic fs;
    logic dn;
  } exp_t;

  exp_t sb[$];
  int   checks      = 0;
  int   failures    = 0;
  int   busy_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Vectors are listed first-cycle-first (MSB of each argument is the first busy cycle).
  task automatic push_vec(input int n, input logic [31:0] xs, input logic [31:0] bvs,
                          input logic [31:0] fss, input logic [31:0] dns);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e.x  = xs[i];
      e.bv = bvs[i];
      e.fs = fss[i];
      e.dn = dns[i];
      sb.push_back(e);
    end
  endtask

  // Monitor: {x_out, bit_valid, frame_start, done} per busy cycle; idle lines otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy === 1'b1) begin
      busy_cycles++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_busy: got busy=1 x=%b bv=%b fs=%b done=%b, expected busy=0 at %0t",
                 bus.x_out, bus.bit_valid, bus.frame_start, bus.done, $time);
      end else begin
        e = sb.pop_front();
        chk("stream{x,bv,fs,done}",
            32'({bus.x_out, bus.bit_valid, bus.frame_start, bus.done}), 32'(e));
      end
    end else begin
      chk("idle{x,bv,fs,done}",
          32'({bus.x_out, bus.bit_valid, bus.frame_start, bus.done}), 32'b1000);
    end
  end

  task automatic start_run(input logic [7:0] r, input logic [3:0] g);
    bus.start      = 1'b1;
    bus.repeat_cnt = r;
    bus.gap_len    = g;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
    end
    chk({nm, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.repeat_cnt = '0;
    bus.gap_len    = '0;
    reset          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_x_out", 32'(bus.x_out), 32'd1);
    chk("reset_flags{bv,fs,busy,done}",
        32'({bus.bit_valid, bus.frame_start, bus.busy, bus.done}), 32'd0);
    chk("reset_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: asynchronous reset after two bits of a pattern
    push_vec(2, 'b01, 'b11, 'b10, 'b00);
    start_run(8'd1, 4'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t1_reset_x_out", 32'(bus.x_out), 32'd1);
    chk("t1_reset_busy", 32'(bus.busy), 32'd0);
    chk("t1_reset_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // 2: single pattern, done one cycle after the last bit
    busy_cycles = 0;
    push_vec(5, 'b01101, 'b11110, 'b10000, 'b00001);
    start_run(8'd1, 4'd0);
    wait_idle("t2");
    chk("t2_sent_cnt", 32'(bus.sent_cnt), 32'd1);
    chk("t2_busy_cycles", 32'(busy_cycles), 32'd5);

    // 3: three patterns with two-cycle gaps
    busy_cycles = 0;
    push_vec(17, 'b0110_11_0110_11_0110_1, 'b1111_00_1111_00_1111_0,
                 'b1000_00_1000_00_1000_0, 'b0000_00_0000_00_0000_1);
    start_run(8'd3, 4'd2);
    wait_idle("t3");
    chk("t3_sent_cnt", 32'(bus.sent_cnt), 32'd3);
    chk("t3_busy_cycles", 32'(busy_cycles), 32'd17);

    // 4: two patterns back-to-back
    busy_cycles = 0;
    push_vec(9, 'b01100110_1, 'b11111111_0, 'b10001000_0, 'b00000000_1);
    start_run(8'd2, 4'd0);
    wait_idle("t4");
    chk("t4_sent_cnt", 32'(bus.sent_cnt), 32'd2);
    chk("t4_busy_cycles", 32'(busy_cycles), 32'd9);

    // 5: zero repeats -> only the done cycle; a start during DONE is ignored
    busy_cycles = 0;
    push_vec(1, 'b1, 'b0, 'b0, 'b1);
    start_run(8'd0, 4'd5);
    bus.start      = 1'b1;
    bus.repeat_cnt = 8'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_busy_cycles", 32'(busy_cycles), 32'd1);
    chk("t5_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: abort on the third bit of the second pattern; start pulsed mid-run is ignored
    busy_cycles = 0;
    push_vec(8, 'b0110_1_011, 'b1111_0_111, 'b1000_0_100, 'b0000_0_000);
    start_run(8'd4, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.repeat_cnt = 8'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    chk("t6_abort_busy", 32'(bus.busy), 32'd0);
    chk("t6_abort_done", 32'(bus.done), 32'd0);
    chk("t6_abort_sent_cnt", 32'(bus.sent_cnt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_busy_cycles", 32'(busy_cycles), 32'd8);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    // 7: abort and start together in IDLE -> start dropped, sent_cnt untouched
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    bus.repeat_cnt = 8'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_sent_cnt", 32'(bus.sent_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
